// File: rtl/tage_pkg.sv
// Shared types for the TAGE update scheduler: update payload, scheduler states,
// default FIFO depth and a saturating counter helper.
package tage_pkg;

  localparam int TAGE_UPD_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [1:0]  pred;
  } tage_upd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } tage_sched_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tage_upd_fifo.sv
// Synchronous FIFO of resolved-branch updates. Head is read combinationally;
// storage is cleared on reset so an empty FIFO presents an all-zero head.
module tage_upd_fifo
  import tage_pkg::*;
#(
  parameter int DEPTH = TAGE_UPD_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  tage_upd_t              din_i,
  input  logic                   pop_i,
  output tage_upd_t              dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  tage_upd_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tage_upd_sched.sv
// Shares the single TAGE table slot between fetch lookups (priority) and queued
// backend updates; a starved update forces a one-cycle fetch stall.
module tage_upd_sched
  import tage_pkg::*;
#(
  parameter int DEPTH      = TAGE_UPD_DEPTH,
  parameter int STARVE_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_valid,
  input  logic [31:0]            fetch_pc,
  output logic                   fetch_ready,
  output logic [1:0]             fetch_pred,
  input  logic                   res_valid,
  input  logic [31:0]            res_pc,
  input  logic                   res_taken,
  input  logic [1:0]             res_pred,
  output logic                   res_ready,
  output logic [31:0]            tage_branch_pc,
  input  logic [1:0]             tage_branch_pred,
  output logic                   tage_update_valid,
  output logic [31:0]            tage_update_pc,
  output logic                   tage_update_taken,
  output logic [1:0]             tage_update_pred,
  output logic [15:0]            force_cnt,
  output logic [1:0]             dbg_state,
  output logic [$clog2(DEPTH):0] dbg_count
);

  localparam int         CW          = $clog2(DEPTH) + 1;
  localparam logic [7:0] STARVE_LAST = 8'(STARVE_MAX - 1);

  tage_sched_state_e state_q;
  logic [7:0]        wait_q;
  logic [15:0]       force_cnt_q;

  tage_upd_t         push_data;
  tage_upd_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              push;
  logic              pop;
  logic [CW-1:0]     cnt_nxt;

  // Lookup path is purely combinational.
  assign tage_branch_pc = fetch_pc;
  assign fetch_pred     = tage_branch_pred;
  assign fetch_ready    = (state_q != FORCE);

  assign res_ready = !fifo_full;
  assign push      = res_valid && res_ready;
  assign push_data = '{pc: res_pc, taken: res_taken, pred: res_pred};

  assign tage_update_valid = !fifo_empty && (!fetch_valid || state_q == FORCE);
  assign pop               = tage_update_valid;
  assign tage_update_pc    = head.pc;
  assign tage_update_taken = head.taken;
  assign tage_update_pred  = head.pred;

  assign force_cnt = force_cnt_q;
  assign dbg_state = state_q;
  assign dbg_count = fifo_count;

  tage_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    cnt_nxt = fifo_count;
    if (push && !pop)      cnt_nxt = fifo_count + CW'(1);
    else if (!push && pop) cnt_nxt = fifo_count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      force_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wait_q <= '0;
          if (cnt_nxt != '0) state_q <= PEND;
        end
        PEND: begin
          if (pop) begin
            wait_q <= '0;
            if (cnt_nxt == '0) state_q <= IDLE;
          end else if (fetch_valid) begin
            // Blocked by fetch: after STARVE_MAX such cycles steal the slot.
            wait_q <= wait_q + 8'd1;
            if (wait_q == STARVE_LAST) state_q <= FORCE;
          end
        end
        FORCE: begin
          wait_q      <= '0;
          force_cnt_q <= sat_inc16(force_cnt_q);
          state_q     <= (cnt_nxt != '0) ? PEND : IDLE;
        end
        default: begin
          state_q <= IDLE;
          wait_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/tage_upd_sched.md
# tage_upd_sched

Update scheduler for `tage_top`. The predictor's tables have a single shared access slot per cycle. This block gives fetch lookups priority over backend update writes. It buffers resolved-branch updates from the backend in a small FIFO and issues them to `tage_top` only on cycles with no fetch lookup. If an update waits too long, the block stalls fetch for exactly one cycle and forces the update through, so training never starves.

## Interface
Parameters:
- `DEPTH`, 4: update FIFO entries; power of two, ≥2.
- `STARVE_MAX`, 8: consecutive blocked cycles before a forced issue; 1..255.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `fetch_valid` in 1: fetch requests a prediction this cycle.
- `fetch_pc` in 32: PC to predict.
- `fetch_ready` out 1: lookup accepted this cycle.
- `fetch_pred` out 2: prediction returned to fetch.
- `res_valid` in 1: backend offers a resolved branch.
- `res_pc` in 32: resolved branch PC.
- `res_taken` in 1: actual direction.
- `res_pred` in 2: prediction made at fetch time.
- `res_ready` out 1: FIFO can accept.
- `tage_branch_pc` out 32: to `tage_top.branch_pc`.
- `tage_branch_pred` in 2: from `tage_top.branch_pred`.
- `tage_update_valid` out 1: to `tage_top.update_valid`.
- `tage_update_pc` out 32, `tage_update_taken` out 1, `tage_update_pred` out 2: update payload.
- `force_cnt` out 16: saturating count of forced issues (debug).

## Operation
- Lookup path is combinational:
  - `tage_branch_pc = fetch_pc`.
  - `fetch_pred = tage_branch_pred`.
  - `fetch_ready = (state != FORCE)`.
- Enqueue: push when `res_valid && res_ready`. `res_ready = !full`. There is no bypass. A pushed entry is eligible to issue in the following cycle at the earliest.
- Issue: the `tage_update_*` payload is the FIFO head, driven combinationally. `tage_update_valid = !empty && (!fetch_valid || state == FORCE)`. Head pops in the same cycle that `tage_update_valid` is high.
- FSM states:
  - **IDLE**: FIFO empty. Go to PEND when count becomes nonzero.
  - **PEND**: FIFO nonempty.
    - Issue cycle: `wait_cnt <= 0`.
    - Blocked cycle (`fetch_valid`): `wait_cnt <= wait_cnt + 1`.
    - If a blocked cycle has `wait_cnt == STARVE_MAX-1`, go to FORCE.
    - Go to IDLE when the FIFO is empty after this cycle's pop and push.
  - **FORCE**: lasts exactly one cycle.
    - `fetch_ready = 0`; the update issues unconditionally.
    - `wait_cnt <= 0`; `force_cnt` increments and saturates at 16'hFFFF.
    - Next state is PEND if the FIFO is nonempty after pop and push, else IDLE.
- Simultaneous push and pop: allowed, count unchanged. With the FIFO full, pop frees a slot only for the next cycle (`res_ready` stays 0 this cycle).
- Order: updates issue strictly in FIFO (resolution) order. No entry is ever dropped.
- `wait_cnt` is 8 bits. `count` is `$clog2(DEPTH)+1` bits. Pointers wrap modulo `DEPTH`.

## Timing
- Reset (async assert, sync release) gives:
  - `state=IDLE`, FIFO empty, `wait_cnt=0`, `force_cnt=0`.
  - `res_ready=1`, `tage_update_valid=0`, `fetch_ready=1`.
  - `tage_update_pc/taken/pred` = 0 (head storage cleared).
- Reset mid-operation discards all buffered updates.
- Minimum update latency: push at edge N, issue during cycle N+1 if `fetch_valid=0`.
- Worst-case head latency under continuous fetch: `STARVE_MAX` blocked cycles, then FORCE on cycle `STARVE_MAX+1`.
- Fetch stall is at most 1 cycle per `STARVE_MAX+1` cycles.
- Lookup path adds no cycles (combinational through the block).

## Structure
- `tage_pkg` holds:
  - `tage_upd_t` (struct: `pc[31:0]`, `taken`, `pred[1:0]`).
  - `tage_sched_state_e` (IDLE, PEND, FORCE).
  - Default `TAGE_UPD_DEPTH`.
- Sub-module `tage_upd_fifo`: synchronous FIFO of `tage_upd_t` with `full`, `empty`, `count`. The scheduler FSM and counters stay in `tage_upd_sched`.

## Test plan
- Reset: assert `rst_n=0` asynchronously mid-cycle with 3 entries queued → outputs immediately at reset values; after release `res_ready=1`, and no update ever issues for the old entries.
- Idle drain: `fetch_valid=0`, push pc=0x100 taken=1 pred=2 at edge N → `tage_update_valid=1`, pc=0x100 during cycle N+1, FIFO empty at N+2.
- Priority and starvation: hold `fetch_valid=1`, push one entry, `STARVE_MAX=8` → `tage_update_valid=0` for 8 cycles, then 1 cycle with `fetch_ready=0` and update issued, `force_cnt=1`.
- Full FIFO: `DEPTH=4`, `fetch_valid=1`, push 5 → `res_ready=0` after the 4th push; 5th is accepted only after the first pop; issue order matches push order.
- Simultaneous push and pop: `fetch_valid=0`, continuous pushes → one issue per cycle, count constant at 1, state stays PEND.
- Lookup passthrough: `fetch_pc=0xDEAD_BEE0`, `tage_branch_pred=2'b11` → `tage_branch_pc=0xDEAD_BEE0`, `fetch_pred=2'b11` in the same cycle.
